// File: rtl/fir_accum_sequencer_pkg.sv
// fir_pkg: shared constants and types for the FIR accumulate sequencer.
//   DATA_W    sample / product / adder width
//   NTAPS_DEF default number of taps per output sample
//   state_t   sequencer state (ACCUM collecting taps, DONE presenting sample)
package fir_pkg;
   localparam int DATA_W    = 8;
   localparam int NTAPS_DEF = 4;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;
endpackage

// File: rtl/fir_accum_sequencer_if.sv
// fir_accum_sequencer_if: input product handshake and output sample handshake.
//   in_valid/in_ready/in_data   tap product stream into the sequencer
//   out_valid/out_ready/out_data/ovf  filtered sample stream out of it
//   master: environment side (product source and sample sink)
//   slave : sequencer side
interface fir_accum_sequencer_if;
   import fir_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              ovf;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, ovf
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, ovf
   );
endinterface

// File: rtl/fir_accum_sequencer_tap_counter.sv
// fir_tap_counter: modulo-NTAPS tap index counter.
//   clk, rst_n  clock, asynchronous active-low reset
//   inc         advance the index by one (wraps NTAPS-1 -> 0)
//   clr         synchronous return to 0, overrides inc
//   idx         current tap index
//   wrap        pulses when inc lands on the last tap (frame complete)
module fir_tap_counter #(
   parameter  int NTAPS = 4,
   localparam int TW    = $clog2(NTAPS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          clr,
   output logic [TW-1:0] idx,
   output logic          wrap
);
   logic last;

   assign last = (idx == TW'(NTAPS - 1));
   assign wrap = inc & last & ~clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (clr) begin
         idx <= '0;
      end else if (inc) begin
         idx <= last ? '0 : idx + TW'(1);
      end
   end
endmodule

// File: rtl/fir_accum_sequencer.sv
// fir_accum_sequencer: time-shares one external 8-bit adder across the taps
// of an output sample. Each accepted product is added to the accumulator via
// add_a/add_b -> add_c; after NTAPS products the sum is presented on the
// output handshake together with a sticky carry-out (wrap) flag.
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous frame abort (highest priority)
//   bus         product input and sample output handshakes (slave side)
//   tap_idx     tap expected next, selects the coefficient
//   add_a/add_b operands to the shared adder (accumulator, product)
//   add_c       sum returned combinationally by the shared adder
module fir_accum_sequencer
   import fir_pkg::*;
#(
   parameter  int NTAPS = NTAPS_DEF,
   localparam int TW    = $clog2(NTAPS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   fir_accum_sequencer_if.slave bus,
   output logic [TW-1:0]        tap_idx,
   output logic [DATA_W-1:0]    add_a,
   output logic [DATA_W-1:0]    add_b,
   input  logic [DATA_W-1:0]    add_c
);
   state_t            state, state_nxt;
   logic [DATA_W-1:0] acc;
   logic              ovf_r;
   logic              accept;
   logic              tap_inc;
   logic              frame_end;

   // Unsigned carry-out of acc + product: a modulo sum smaller than the
   // previous accumulator value can only arise from a wrap.
   function automatic logic carried(input logic [DATA_W-1:0] sum,
                                    input logic [DATA_W-1:0] prev);
      return sum < prev;
   endfunction

   assign accept  = bus.in_valid & bus.in_ready;
   assign tap_inc = accept & ~clr;

   fir_tap_counter #(.NTAPS(NTAPS)) u_tap_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (tap_inc),
      .clr   (clr),
      .idx   (tap_idx),
      .wrap  (frame_end)
   );

   assign bus.in_ready  = (state == ACCUM);
   assign bus.out_valid = (state == DONE);
   assign bus.out_data  = acc;
   assign bus.ovf       = ovf_r;
   assign add_a         = acc;
   assign add_b         = bus.in_data;

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = ACCUM;
      end else begin
         case (state)
            ACCUM:   if (frame_end)     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   // Accumulator and sticky wrap flag. Tap 0 discards any stale flag so
   // the flag always describes the frame currently being summed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         ovf_r <= 1'b0;
      end else if (clr) begin
         acc   <= '0;
         ovf_r <= 1'b0;
      end else if (accept) begin
         acc   <= add_c;
         ovf_r <= ((tap_idx == '0) ? 1'b0 : ovf_r) | carried(add_c, acc);
      end else if ((state == DONE) && bus.out_ready) begin
         acc   <= '0;
         ovf_r <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fir_accum_sequencer.sv
// Scoreboard bench for fir_accum_sequencer with NTAPS=4 and an ideal
// external 8-bit adder. Directed frames push their hand-computed result;
// a negedge monitor pops and compares on every output handshake.
module tb_fir_accum_sequencer;
   import fir_pkg::*;

   localparam int NT = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic [1:0] tap_idx;
   logic [7:0] add_a, add_b, add_c;

   fir_accum_sequencer_if bus ();

   fir_accum_sequencer #(.NTAPS(NT)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .bus     (bus),
      .tap_idx (tap_idx),
      .add_a   (add_a),
      .add_b   (add_b),
      .add_c   (add_c)
   );

   assign add_c = add_a + add_b;

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int exp_tap = 0;

   typedef struct packed {
      logic [7:0] data;
      logic       ovf;
   } sample_t;
   sample_t exp_q[$];

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic o);
      sample_t s;
      s.data = d;
      s.ovf  = o;
      exp_q.push_back(s);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", int'(bus.out_data), -1);
         end else begin
            sample_t s;
            s = exp_q.pop_front();
            chk("out_data", int'(bus.out_data), int'(s.data));
            chk("out_ovf", int'(bus.ovf), int'(s.ovf));
         end
      end
   end

   // Present one product and hold it until accepted; checks tap_idx at accept.
   task automatic put(input logic [7:0] d);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 0, 1);
      chk("tap_idx_at_accept", int'(tap_idx), exp_tap);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      exp_tap = (exp_tap == NT - 1) ? 0 : exp_tap + 1;
   endtask

   task automatic frame(input logic [7:0] a, b, c, d);
      put(a); put(b); put(c); put(d);
   endtask

   initial begin
      logic       pat [7];
      logic [7:0] prod [4];
      int         k;
      int         n;

      bus.in_valid  = 1'b0;
      bus.in_data   = 8'd0;
      bus.out_ready = 1'b1;
      #12;
      // reset state
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      chk("rst_ovf", int'(bus.ovf), 0);
      chk("rst_tap_idx", int'(tap_idx), 0);
      chk("rst_add_a", int'(add_a), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // plain sum, back to back
      push(8'd100, 1'b0);
      frame(8'd10, 8'd20, 8'd30, 8'd40);
      chk("latency_out_valid", int'(bus.out_valid), 1);
      chk("tap_idx_wrapped", int'(tap_idx), 0);

      // wrap, then a clean frame clears the flag
      push(8'd44, 1'b1);
      frame(8'd200, 8'd100, 8'd0, 8'd0);
      push(8'd4, 1'b0);
      frame(8'd1, 8'd1, 8'd1, 8'd1);
      @(posedge clk); #1;

      // backpressure: 200+100+5+0 = 305 -> 49 with wrap
      bus.out_ready = 1'b0;
      push(8'd49, 1'b1);
      frame(8'd200, 8'd100, 8'd5, 8'd0);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = (i % 2 == 0);
         bus.in_data  = 8'd77;
         @(negedge clk);
         chk("bp_out_valid", int'(bus.out_valid), 1);
         chk("bp_out_data", int'(bus.out_data), 49);
         chk("bp_ovf", int'(bus.ovf), 1);
         chk("bp_in_ready", int'(bus.in_ready), 0);
         chk("bp_tap_idx", int'(tap_idx), 0);
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;

      // input gaps
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      prod = '{8'd5, 8'd6, 8'd7, 8'd8};
      push(8'd26, 1'b0);
      k = 0;
      for (int i = 0; i < 7; i++) begin
         bus.in_valid = pat[i];
         bus.in_data  = prod[k];
         @(negedge clk);
         chk("gap_tap_idx", int'(tap_idx), exp_tap);
         @(posedge clk); #1;
         if (pat[i]) begin
            k++;
            exp_tap = (exp_tap == NT - 1) ? 0 : exp_tap + 1;
         end
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;

      // clr mid-frame aborts the partial 7+9
      put(8'd7); put(8'd9);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      exp_tap = 0;
      chk("clr_tap_idx", int'(tap_idx), 0);
      chk("clr_acc", int'(add_a), 0);
      push(8'd10, 1'b0);
      frame(8'd1, 8'd2, 8'd3, 8'd4);
      @(posedge clk); #1;

      // clr during DONE drops the pending sample
      bus.out_ready = 1'b0;
      frame(8'd1, 8'd1, 8'd1, 8'd1);
      chk("clr_done_valid_before", int'(bus.out_valid), 1);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk("clr_done_valid_after", int'(bus.out_valid), 0);
      chk("clr_done_data", int'(bus.out_data), 0);
      bus.out_ready = 1'b1;

      // asynchronous reset mid-frame
      put(8'd50); put(8'd50); put(8'd50);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_in_ready", int'(bus.in_ready), 1);
      chk("arst_out_valid", int'(bus.out_valid), 0);
      chk("arst_out_data", int'(bus.out_data), 0);
      chk("arst_ovf", int'(bus.ovf), 0);
      chk("arst_tap_idx", int'(tap_idx), 0);
      chk("arst_add_a", int'(add_a), 0);
      @(negedge clk); rst_n = 1'b1;
      exp_tap = 0;
      @(posedge clk); #1;
      push(8'd200, 1'b0);
      frame(8'd50, 8'd50, 8'd50, 8'd50);

      // drain scoreboard
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
